// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the asynchronous FIFO pointer controllers.
// Gray/binary conversions work on a fixed maximum width; callers zero-extend
// narrower pointers and truncate the result, which leaves the value unchanged
// because zero upper bits do not disturb either conversion.
package fifo_pkg;

    localparam int PTR_W_MAX = 32;

    // Pointer width including the wrap bit for a given power-of-two depth
    function automatic int ptr_size(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
        logic [PTR_W_MAX-1:0] bin;
        logic                 acc;
        bin = '0;
        acc = 1'b0;
        for (int i = PTR_W_MAX - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary conversion (XOR prefix from the MSB).
// Shared by the write- and read-side pointer controllers.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position
    always_comb begin
        bin = '0;
        bin[W-1] = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer controller of the asynchronous FIFO.
// Drives memory write enable/address, publishes a registered Gray write
// pointer, and derives FULL / FILL_LEVEL from the synchronized Gray read
// pointer. Optional almost-full flag: define FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int PTR_SIZE  = ptr_size(MEM_DEPTH),
    parameter int AF_LEVEL  = MEM_DEPTH - 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                W_INC,
    input  logic [PTR_SIZE-1:0] R_PTR_SYNC,
    output logic                W_EN,
    output logic [PTR_SIZE-2:0] W_ADDR,
    output logic [PTR_SIZE-1:0] W_PTR_GRAY,
    output logic                FULL,
    output logic [PTR_SIZE-1:0] FILL_LEVEL,
    output logic                ALMOST_FULL
);

    // Reject configurations the pointer arithmetic cannot support
    if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || AF_LEVEL > MEM_DEPTH) begin : g_bad_cfg
        $error("fifo_wr_ctrl: MEM_DEPTH must be a power of two >= 4 and AF_LEVEL <= MEM_DEPTH");
    end

    logic [PTR_SIZE-1:0] wbin;
    logic [PTR_SIZE-1:0] wbin_next;
    logic [PTR_SIZE-1:0] gray_next;
    logic [PTR_SIZE-1:0] rbin;
    logic [PTR_SIZE-1:0] level_next;
    logic                full_next;

    fifo_gray2bin #(
        .W(PTR_SIZE)
    ) u_rptr_g2b (
        .gray(R_PTR_SYNC),
        .bin (rbin)
    );

    assign W_EN   = W_INC & ~FULL;
    assign W_ADDR = wbin[PTR_SIZE-2:0];

    // Next pointer, its Gray form, and the flags derived against the read pointer
    always_comb begin
        wbin_next  = wbin + {{(PTR_SIZE-1){1'b0}}, W_EN};
        gray_next  = PTR_SIZE'(bin2gray(PTR_W_MAX'(wbin_next)));
        // Full: write pointer one lap ahead of read pointer (top two Gray bits inverted)
        full_next  = (gray_next == {~R_PTR_SYNC[PTR_SIZE-1:PTR_SIZE-2], R_PTR_SYNC[PTR_SIZE-3:0]});
        level_next = wbin_next - rbin;
    end

    // Pointer and status registers; reset overrides any same-cycle write
    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin       <= '0;
            W_PTR_GRAY <= '0;
            FULL       <= 1'b0;
            FILL_LEVEL <= '0;
        end else begin
            wbin       <= wbin_next;
            W_PTR_GRAY <= gray_next;
            FULL       <= full_next;
            FILL_LEVEL <= level_next;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    // Almost-full registered with the same timing as FULL
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALMOST_FULL <= 1'b0;
        end else begin
            ALMOST_FULL <= (level_next >= PTR_SIZE'(AF_LEVEL));
        end
    end
`else
    assign ALMOST_FULL = 1'b0;
`endif

endmodule
